// File: rtl/instruction_prefetch_pkg.sv
// Shared types for the MIPS instruction fetch front-end: fetch FSM states,
// word size and the queued {pc, instr} entry.
package mips_fetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_e;

  localparam int WORD_BYTES = 4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/instruction_prefetch_if.sv
// Memory-side and decode-side signals of the instruction prefetch unit.
interface instruction_prefetch_if;
  // mem_req/mem_addr stay stable from issue until the cycle mem_ack is high;
  // the word is taken on that edge. A decode entry transfers on any rising
  // edge where out_valid && out_ready. redirect is a single-cycle pulse.
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [31:0] out_instr;
  logic        redirect;
  logic [31:0] redirect_pc;

  modport slave (
    output mem_req, mem_addr, out_valid, out_pc, out_instr,
    input  mem_ack, mem_rdata, out_ready, redirect, redirect_pc
  );

  modport master (
    input  mem_req, mem_addr, out_valid, out_pc, out_instr,
    output mem_ack, mem_rdata, out_ready, redirect, redirect_pc
  );
endinterface

// File: rtl/instruction_prefetch_fifo.sv
// prefetch_fifo: DEPTH-entry synchronous FIFO of fetch entries with flush.
// Flush wins over push/pop; DEPTH must be a power of two.
module prefetch_fifo
  import mips_fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  fetch_entry_t             push_data,
  input  logic                     pop,
  output fetch_entry_t             head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  fetch_entry_t    entries [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && (count != FULL_COUNT);
  assign do_pop  = pop && (count != '0);
  assign head    = entries[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) entries[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        entries[wr_ptr] <= push_data;
        wr_ptr          <= wr_ptr + AW'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW + 1)'(1);
        2'b01:   count <= count - (AW + 1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/instruction_prefetch.sv
// instruction_prefetch: owns the fetch PC, issues one word read at a time and
// queues {pc, instr} for decode. Optional PREFETCH_BYPASS_EN forwards an ack
// straight to decode when the queue is empty.
module instruction_prefetch
  import mips_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  rst,
  instruction_prefetch_if.slave bus,
  output fetch_state_e          fsm_state
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  fetch_state_e  state, state_next;
  logic [31:0]   fetch_pc, fetch_pc_next;
  logic          req_q, req_next;
  logic [31:0]   addr_q, addr_next;
  logic          accept_word;
  logic [CW-1:0] fifo_count;
  logic          fifo_valid;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          push;
  logic          pop;
  logic          bypass_hit;
  logic          unused_pc_bits;

  assign unused_pc_bits = ^bus.redirect_pc[1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      fetch_pc <= RESET_PC;
      req_q    <= 1'b0;
      addr_q   <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_q    <= req_next;
      addr_q   <= addr_next;
    end
  end

  // A request is never withdrawn: a redirect while waiting parks in DRAIN
  // until the old ack arrives, and that word is dropped.
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_next      = req_q;
    addr_next     = addr_q;
    accept_word   = 1'b0;
    if (bus.redirect) fetch_pc_next = {bus.redirect_pc[31:2], 2'b00};
    case (state)
      IDLE: begin
        if (!bus.redirect && (fifo_count < FULL_COUNT)) begin
          req_next   = 1'b1;
          addr_next  = fetch_pc;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (bus.mem_ack) begin
          req_next   = 1'b0;
          state_next = IDLE;
          if (!bus.redirect) begin
            accept_word   = 1'b1;
            fetch_pc_next = fetch_pc + 32'(WORD_BYTES);
          end
        end else if (bus.redirect) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (bus.mem_ack) begin
          req_next   = 1'b0;
          state_next = IDLE;
        end
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase
  end

  assign fifo_valid = (fifo_count != '0);
  assign push_data  = '{pc: addr_q, instr: bus.mem_rdata};
  assign push       = accept_word && !(bypass_hit && bus.out_ready);
  assign pop        = fifo_valid && bus.out_ready;

`ifdef PREFETCH_BYPASS_EN
  assign bypass_hit    = (state == WAIT) && bus.mem_ack && !bus.redirect && !fifo_valid;
  assign bus.out_valid = bypass_hit || fifo_valid;
  assign bus.out_pc    = bypass_hit ? addr_q        : (fifo_valid ? head.pc    : '0);
  assign bus.out_instr = bypass_hit ? bus.mem_rdata : (fifo_valid ? head.instr : '0);
`else
  assign bypass_hit    = 1'b0;
  assign bus.out_valid = fifo_valid;
  assign bus.out_pc    = fifo_valid ? head.pc    : '0;
  assign bus.out_instr = fifo_valid ? head.instr : '0;
`endif

  prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (bus.redirect),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (head),
    .count     (fifo_count)
  );

  assign bus.mem_req  = req_q;
  assign bus.mem_addr = addr_q;
  assign fsm_state    = state;

endmodule
